// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared widths, state encoding and product helper for the complex multiply sequencer
package cmul_pkg;

    localparam int OPW = 4;
    localparam int PW  = 2 * OPW;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_SUB  = 3'd2,
        ST_ADD  = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    // Signed OPWxOPW product, sign-extended to PW bits.
    function automatic logic [PW-1:0] smul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        ae = PW'($signed(a));
        be = PW'($signed(b));
        return ae * be;
    endfunction

endpackage

// File: rtl/cmul_seq_ctrl_if.sv
// rtl/cmul_seq_ctrl_if.sv - operand/result handshake bundle between source, sequencer and consumer
interface cmul_seq_ctrl_if;
    import cmul_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] ar;
    logic [OPW-1:0] ai;
    logic [OPW-1:0] br;
    logic [OPW-1:0] bi;
    logic           out_valid;
    logic           out_ready;
    logic [PW-1:0]  re;
    logic [PW-1:0]  im;
    logic           re_ovf;
    logic           im_ovf;
    logic           busy;

    modport master (
        output in_valid, ar, ai, br, bi, out_ready,
        input  in_ready, out_valid, re, im, re_ovf, im_ovf, busy
    );

    modport slave (
        input  in_valid, ar, ai, br, bi, out_ready,
        output in_ready, out_valid, re, im, re_ovf, im_ovf, busy
    );

endinterface

// File: rtl/AdderAndSubtractor_8bit.sv
// rtl/AdderAndSubtractor_8bit.sv - 8-bit two's complement adder/subtractor with signed overflow flag
module AdderAndSubtractor_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       add_bar_sub_i,
    output logic [7:0] res_o,
    output logic       cout_o,
    output logic       ovf_o
);

    logic [7:0] b_x;

    // Subtract as A + ~B + 1; overflow judged against the inverted operand.
    assign b_x             = b_i ^ {8{add_bar_sub_i}};
    assign {cout_o, res_o} = {1'b0, a_i} + {1'b0, b_x} + {8'b0, add_bar_sub_i};
    assign ovf_o           = (a_i[7] == b_x[7]) & (res_o[7] != a_i[7]);

endmodule

// File: rtl/cmul_seq_ctrl.sv
// rtl/cmul_seq_ctrl.sv - sequencer for a 4-bit signed complex multiply using one shared add/sub unit
module cmul_seq_ctrl
    import cmul_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    cmul_seq_ctrl_if.slave bus
);

    state_e         state_q;
    logic [OPW-1:0] ar_q, ai_q, br_q, bi_q;
    logic [PW-1:0]  pac_q, pbd_q, pad_q, pbc_q;
    logic [PW-1:0]  re_q, im_q;
    logic           re_ovf_q, im_ovf_q;
    logic           out_valid_q, busy_q;

    logic [PW-1:0]  add_a, add_b, add_res;
    logic           add_sub, add_ovf, adder_cout_unused;

    // Only SUB subtracts; every other state presents the im operands with add selected.
    assign add_sub = (state_q == ST_SUB);
    assign add_a   = add_sub ? pac_q : pad_q;
    assign add_b   = add_sub ? pbd_q : pbc_q;

    AdderAndSubtractor_8bit u_addsub (
        .a_i           (add_a),
        .b_i           (add_b),
        .add_bar_sub_i (add_sub),
        .res_o         (add_res),
        .cout_o        (adder_cout_unused),
        .ovf_o         (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            pac_q       <= '0;
            pbd_q       <= '0;
            pad_q       <= '0;
            pbc_q       <= '0;
            re_q        <= '0;
            im_q        <= '0;
            re_ovf_q    <= 1'b0;
            im_ovf_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        ar_q    <= bus.ar;
                        ai_q    <= bus.ai;
                        br_q    <= bus.br;
                        bi_q    <= bus.bi;
                        busy_q  <= 1'b1;
                        state_q <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    pac_q   <= smul(ar_q, br_q);
                    pbd_q   <= smul(ai_q, bi_q);
                    pad_q   <= smul(ar_q, bi_q);
                    pbc_q   <= smul(ai_q, br_q);
                    state_q <= ST_SUB;
                end
                ST_SUB: begin
                    re_q     <= add_res;
                    re_ovf_q <= add_ovf;
                    state_q  <= ST_ADD;
                end
                ST_ADD: begin
                    im_q        <= add_res;
                    im_ovf_q    <= add_ovf;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.re        = re_q;
    assign bus.im        = im_q;
    assign bus.re_ovf    = re_ovf_q;
    assign bus.im_ovf    = im_ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
// tb/tb_cmul_seq_ctrl.sv - scoreboard bench for the complex multiply sequencer
module tb_cmul_seq_ctrl;

    typedef struct packed {
        logic [7:0] re;
        logic [7:0] im;
        logic       re_ovf;
        logic       im_ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmul_seq_ctrl_if bus();

    cmul_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Result monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none",
                         {bus.re, bus.im, bus.re_ovf, bus.im_ovf});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", {14'd0, bus.re, bus.im, bus.re_ovf, bus.im_ovf}, {14'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input exp_t e);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(n < 50), 32'd1);
        bus.ar = a;
        bus.ai = b;
        bus.br = c;
        bus.bi = d;
        bus.in_valid = 1'b1;
        exp_q.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        bus.ar = 4'h0;
        bus.ai = 4'h0;
        bus.br = 4'h0;
        bus.bi = 4'h0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, n, 32'd3);
    endtask

    initial begin
        int bad;
        int last_acc;
        logic [3:0] ops [4][4];
        exp_t       res [4];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ar = 4'h0;
        bus.ai = 4'h0;
        bus.br = 4'h0;
        bus.bi = 4'h0;

        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_re_im", {bus.re, bus.im}, 0);
        chk("rst_flags", {bus.re_ovf, bus.im_ovf}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();

        // (3+2j)*(1+4j) = -5 + 14j
        bus.out_ready = 1'b1;
        send(4'h3, 4'h2, 4'h1, 4'h4, '{8'hFB, 8'h0E, 1'b0, 1'b0});
        chk("busy_after_accept", bus.busy, 1);
        wait_out("latency_op1");
        tick();

        // (-8-8j)^2 = 0 + 128j, im wraps with overflow
        send(4'h8, 4'h8, 4'h8, 4'h8, '{8'h00, 8'h80, 1'b0, 1'b1});
        wait_out("latency_op2");
        tick();

        // (7-8j)*(-8+7j) = 0 + 113j
        send(4'h7, 4'h8, 4'h8, 4'h7, '{8'h00, 8'h71, 1'b0, 1'b0});
        wait_out("latency_op3");
        tick();

        // Back-pressure: (-1+2j)*(3-1j) = -1 + 7j held while out_ready low
        bus.out_ready = 1'b0;
        send(4'hF, 4'h2, 4'h3, 4'hF, '{8'hFF, 8'h07, 1'b0, 1'b0});
        wait_out("latency_op4");
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.out_valid || bus.re !== 8'hFF || bus.im !== 8'h07 || bus.in_ready || !bus.busy)
                bad++;
            bus.in_valid = i[0];
            bus.ar = 4'h7;
            bus.ai = 4'h7;
            bus.br = 4'h7;
            bus.bi = 4'h7;
            tick();
        end
        chk("hold_in_out_state", bad, 0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("out_valid_dropped", bus.out_valid, 0);
        chk("in_ready_after_out", bus.in_ready, 1);
        tick();

        // Reset while the operation is in SUB
        send(4'h3, 4'h3, 4'h3, 4'h3, '{8'h00, 8'h12, 1'b0, 1'b0});
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_re_im", {bus.re, bus.im}, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) bad++;
        end
        chk("midrst_no_result", bad, 0);

        // Streaming: in_valid and out_ready held high
        ops[0] = '{4'h1, 4'h1, 4'h1, 4'h1}; res[0] = '{8'h00, 8'h02, 1'b0, 1'b0};
        ops[1] = '{4'hE, 4'h3, 4'h4, 4'hF}; res[1] = '{8'hFB, 8'h0E, 1'b0, 1'b0};
        ops[2] = '{4'h5, 4'h0, 4'hD, 4'h6}; res[2] = '{8'hF1, 8'h1E, 1'b0, 1'b0};
        ops[3] = '{4'h9, 4'h9, 4'h7, 4'h9}; res[3] = '{8'h9E, 8'h00, 1'b0, 1'b0};
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (!bus.in_ready && n < 50) begin
                tick();
                n++;
            end
            chk("stream_ready_wait", 32'(n < 50), 32'd1);
            bus.ar = ops[k][0];
            bus.ai = ops[k][1];
            bus.br = ops[k][2];
            bus.bi = ops[k][3];
            exp_q.push_back(res[k]);
            tick();
            if (k > 0) chk("stream_interval", cyc - last_acc, 32'd5);
            last_acc = cyc;
        end
        bus.in_valid = 1'b0;

        bad = 0;
        while (exp_q.size() != 0 && bad < 50) begin
            tick();
            bad++;
        end
        chk("drain", exp_q.size(), 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
